// File: rtl/debug_page_source.sv
// Paged debug-word store feeding the 8x4 LED strobe driver, with on-chip
// synchronised/debounced page-step and freeze buttons.

module debug_page_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    logic                     sync1_q, sync2_q;
    logic                     state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Raw button is fully asynchronous; two flops before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + DEBOUNCE_BITS'(1);
        end else begin
            // Only the falling (press) transition is an event; release is silent.
            state_d = sync2_q;
            cnt_d   = '0;
            press_o = ~sync2_q;
        end
    end

endmodule

module debug_page_source #(
    parameter int NUM_PAGES     = 4,
    parameter int DEBOUNCE_BITS = 16,
    localparam int PAGE_W       = $clog2(NUM_PAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PAGE_W-1:0] wr_page,
    input  logic [31:0]       wr_data,
    input  logic              btn_next_n,
    input  logic              btn_freeze_n,
    output logic [7:0]        column_1,
    output logic [7:0]        column_2,
    output logic [7:0]        column_3,
    output logic [7:0]        column_4,
    output logic [PAGE_W-1:0] current_page,
    output logic              frozen
);

    localparam int NUM_BTNS = 2;
    localparam int BTN_NEXT = 0;
    localparam int BTN_FRZ  = 1;

    logic [NUM_PAGES-1:0][31:0] pages_q;
    logic [31:0]                disp_q;
    logic [PAGE_W-1:0]          page_q, page_d;
    logic                       frozen_q, frozen_d;
    logic                       wr_ready_q;

    logic [NUM_BTNS-1:0]        btn_raw_n;
    logic [NUM_BTNS-1:0]        btn_press;

    assign btn_raw_n[BTN_NEXT] = btn_next_n;
    assign btn_raw_n[BTN_FRZ]  = btn_freeze_n;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        debug_page_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (btn_raw_n[b]),
            .press_o (btn_press[b])
        );
    end

    // Freeze wins over a simultaneous next press; next is ignored while frozen.
    always_comb begin
        frozen_d = frozen_q;
        page_d   = page_q;
        if (btn_press[BTN_FRZ]) begin
            frozen_d = ~frozen_q;
        end else if (btn_press[BTN_NEXT] && !frozen_q) begin
            page_d = page_q + PAGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready_q <= 1'b0;
            frozen_q   <= 1'b0;
            page_q     <= '0;
        end else begin
            wr_ready_q <= 1'b1;
            frozen_q   <= frozen_d;
            page_q     <= page_d;
        end
    end

    // Storage is written regardless of freeze; the display reads the
    // pre-edge contents, so a write shows one edge after it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pages_q <= '0;
        end else if (wr_valid && wr_ready_q) begin
            pages_q[wr_page] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
        end else if (!frozen_q) begin
            disp_q <= pages_q[page_q];
        end
    end

    assign wr_ready     = wr_ready_q;
    assign frozen       = frozen_q;
    assign current_page = page_q;
    assign column_1     = disp_q[31:24];
    assign column_2     = disp_q[23:16];
    assign column_3     = disp_q[15:8];
    assign column_4     = disp_q[7:0];

endmodule

// File: doc/debug_page_source.md
# debug_page_source

Paged source stage for the 8x4 LED debug display. Holds NUM_PAGES 32-bit debug words written by the core over a valid/ready port and presents one page at a time as four 8-bit column bytes to the LED strobe driver. Two raw board buttons are synchronised and debounced on-chip: one steps the shown page, one freezes the shown snapshot so a fast-changing value can be read by eye.

## Interface

Parameters:
- NUM_PAGES, 4, number of stored words; power of two, 2..16; PAGE_W = $clog2(NUM_PAGES)
- DEBOUNCE_BITS, 16, button must disagree with its debounced state for 2^DEBOUNCE_BITS consecutive cycles to flip (~5.5 ms at 12 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accept
- wr_page  in  PAGE_W  destination page
- wr_data  in  32  word to store
- btn_next_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
- btn_freeze_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
- column_1  out  8  displayed word [31:24]
- column_2  out  8  displayed word [23:16]
- column_3  out  8  displayed word [15:8]
- column_4  out  8  displayed word [7:0]
- current_page  out  PAGE_W  selected page
- frozen  out  1  snapshot held

## Operation

- Storage: NUM_PAGES x 32 registers, all 0 on reset. Handshake wr_valid && wr_ready at an edge writes wr_data to page wr_page at that edge. Out-of-range impossible (power-of-two depth).
- wr_ready: registered; 0 during rst, 1 from the first clk edge after rst deasserts, then constantly 1. Writes are never blocked by freeze.
- Display register (32 bits, drives column_1..4): when frozen=0, loads pages[current_page] every edge; when frozen=1, holds.
- Button path, per button, identical: 2-flop synchroniser (reset to 1), debounced state (reset 1 = released), counter of DEBOUNCE_BITS bits (reset 0).
  - Edge with synced == state: counter <= 0.
  - Edge with synced != state and counter != all-ones: counter++.
  - Edge with synced != state and counter == all-ones: state <= synced, counter <= 0; if new state is 0, a press event fires at this same edge.
- Freeze press: frozen <= ~frozen.
- Next press: if frozen=0 at the edge, current_page <= current_page + 1, wrapping NUM_PAGES-1 -> 0; if frozen=1, ignored.
- Both presses at the same edge: freeze toggles, next ignored.
- Release edges produce no event.

## Timing

- Reset values: column_1..4 = 0, current_page = 0, frozen = 0, wr_ready = 0.
- rst is asynchronous: asserting mid-debounce or mid-write clears all state immediately; a handshake at the edge coinciding with rst is dropped.
- Write latency: handshake at edge N updates storage at N; if that page is selected and frozen=0, columns show it after edge N+1.
- Write and page step at the same edge: the display loads the new page at N+1, including that write.
- Button latency: button low before edge E0 -> synced low after E1 -> counter increments at E2..E(2^DEBOUNCE_BITS) -> state flips and event applies at E(2^DEBOUNCE_BITS+1). Columns follow one edge later.
- Any bounce back to the debounced level restarts the count.
- Unfreeze at edge F: the display reloads at F+1.

## Test plan

- Reset, then write 0xDEADBEEF to page 0 at edge N -> columns after N+1 read 0xDE,0xAD,0xBE,0xEF; wr_ready=0 during rst, 1 one edge after release.
- DEBOUNCE_BITS=2, NUM_PAGES=4, pages = 0x11111111..0x44444444. Hold btn_next_n low -> current_page 0->1 at E5, columns 0x22 at E6. Four clean presses wrap back to page 0.
- Bounce pattern low 3 cycles, high 1, low 3, high: no page change. Low 5 stable cycles: exactly one increment.
- Freeze press with page 1 shown, then write 0xCAFEF00D to page 1: columns stay 0x22 and next presses are ignored. Second freeze press: columns show 0xCA,0xFE,0xF0,0x0D one edge after unfreeze.
- Both buttons' events on the same edge -> frozen=1, current_page unchanged.
- Assert rst mid-debounce with page 2 selected and frozen -> all outputs 0 immediately. A subsequent half-debounced press does not count.
